// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM-like port arbiter: FSM state encoding and
// bus size codes.
package sram_arbiter_pkg;

  // Arbiter FSM states: idle grant decision, then address / data phase
  // for whichever requester won.
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_ADDR = 3'd1,
    ARB_D_DATA = 3'd2,
    ARB_I_ADDR = 3'd3,
    ARB_I_DATA = 3'd4
  } arb_state_e;

  // Transfer size codes on the SRAM-like interface.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

endpackage

// File: rtl/sram_arbiter_perf_cnt.sv
// Performance counters for sram_arbiter. Compiled only when
// ARB_PERF_CNT_EN is defined; the default build has no such module.
`ifdef ARB_PERF_CNT_EN
module sram_arbiter_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_done,
  input  logic        data_done,
  input  logic        wait_cycle,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_data_cnt,
  output logic [31:0] perf_wait_cnt
);

  // Free-running event counters; they wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_cnt <= '0;
      perf_data_cnt <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (inst_done)  perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (data_done)  perf_data_cnt <= perf_data_cnt + 32'd1;
      if (wait_cycle) perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like port between instruction fetch and
// data access. Data wins by default, but after DATA_PRIO_MAX consecutive
// data grants with a fetch waiting, the fetch is forced through. Only one
// transaction is outstanding at a time. A fetch flush (inst_cancel) either
// aborts a not-yet-accepted fetch or marks an in-flight one to be dropped.
// Optional feature macro: ARB_PERF_CNT_EN adds perf_inst_cnt,
// perf_data_cnt and perf_wait_cnt outputs.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_PRIO_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // bridge side
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_data_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_PRIO_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_PRIO_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  // State, starvation counter and drop flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed by the comb logic.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: grant decision in IDLE, phase progress otherwise.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and a latch is never inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      ARB_IDLE: begin
        if (data_req && (cnt_q < CNT_MAX || !inst_req)) begin
          state_d = ARB_D_ADDR;
          // Grant below CNT_MAX guaranteed when inst_req is high, so the
          // increment cannot overflow past the limit.
          cnt_d   = inst_req ? cnt_q + 1'b1 : '0;
        end else if (inst_req) begin
          state_d = ARB_I_ADDR;
          cnt_d   = '0;
        end
      end
      ARB_D_ADDR: begin
        if (bus_addr_ok) state_d = ARB_D_DATA;
      end
      ARB_D_DATA: begin
        if (bus_data_ok) state_d = ARB_IDLE;
      end
      ARB_I_ADDR: begin
        if (bus_addr_ok) begin
          state_d = ARB_I_DATA;
          // A flush in the accept cycle still issues the read; its
          // response must be swallowed.
          drop_d  = inst_cancel;
        end else if (inst_cancel) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_I_DATA: begin
        if (bus_data_ok) begin
          state_d = ARB_IDLE;
          drop_d  = 1'b0;
        end else if (inst_cancel) begin
          drop_d  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic: route the bus to the granted requester, zero elsewhere.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_wstrb    = 4'd0;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    case (state_q)
      ARB_D_ADDR: begin
        bus_req      = 1'b1;
        bus_wr       = data_wr;
        bus_size     = data_size;
        bus_wstrb    = data_wstrb;
        bus_addr     = data_addr;
        bus_wdata    = data_wdata;
        data_addr_ok = bus_addr_ok;
      end
      ARB_D_DATA: begin
        data_data_ok = bus_data_ok;
        data_rdata   = bus_data_ok ? bus_rdata : '0;
      end
      ARB_I_ADDR: begin
        bus_req      = 1'b1;
        bus_size     = SIZE_W;
        bus_addr     = inst_addr;
        inst_addr_ok = bus_addr_ok;
      end
      ARB_I_DATA: begin
        inst_data_ok = bus_data_ok & ~drop_q;
        inst_rdata   = (bus_data_ok & ~drop_q) ? bus_rdata : '0;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  // A cycle counts as waiting when any request is up without its accept.
  sram_arbiter_perf_cnt u_perf_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_done     (inst_data_ok),
    .data_done     (data_data_ok),
    .wait_cycle    ((inst_req & ~inst_addr_ok) | (data_req & ~data_addr_ok)),
    .perf_inst_cnt (perf_inst_cnt),
    .perf_data_cnt (perf_data_cnt),
    .perf_wait_cnt (perf_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations,
// then randomized requesters and bridge, with a transaction-level model
// checked against every output on every falling clock edge.
module tb_sram_arbiter;

  localparam int PRIO = 4;

  logic        clk;
  logic        rst_n;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_wait_cnt;
`endif

  sram_arbiter #(.DATA_PRIO_MAX(PRIO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_inst_cnt(perf_inst_cnt),
    .perf_data_cnt(perf_data_cnt),
    .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one transaction record (who owns the bus, whether its
  // address was accepted, whether its response is to be dropped) plus the
  // count of data grants made while a fetch was waiting.
  // ---------------------------------------------------------------------
  bit          m_busy, m_inst, m_acc, m_drop;
  int          m_streak;
  logic [31:0] pc_inst, pc_data, pc_wait;

  always @(negedge clk) begin : compare
    logic        e_breq, e_bwr, e_iaok, e_idok, e_daok, e_ddok;
    logic [1:0]  e_bsize;
    logic [3:0]  e_bwstrb;
    logic [31:0] e_baddr, e_bwdata, e_irdata, e_drdata;
    e_breq = 0; e_bwr = 0; e_bsize = 0; e_bwstrb = 0; e_baddr = 0; e_bwdata = 0;
    e_iaok = 0; e_idok = 0; e_irdata = 0; e_daok = 0; e_ddok = 0; e_drdata = 0;
    if (rst_n && m_busy) begin
      if (!m_acc) begin
        e_breq = 1;
        if (m_inst) begin
          e_bsize = 2'd2;
          e_baddr = inst_addr;
          e_iaok  = bus_addr_ok;
        end else begin
          e_bwr    = data_wr;
          e_bsize  = data_size;
          e_bwstrb = data_wstrb;
          e_baddr  = data_addr;
          e_bwdata = data_wdata;
          e_daok   = bus_addr_ok;
        end
      end else if (m_inst) begin
        e_idok   = bus_data_ok && !m_drop;
        e_irdata = e_idok ? bus_rdata : 32'd0;
      end else begin
        e_ddok   = bus_data_ok;
        e_drdata = bus_data_ok ? bus_rdata : 32'd0;
      end
    end
    check("m_bus_req",      32'(bus_req),      32'(e_breq));
    check("m_bus_wr",       32'(bus_wr),       32'(e_bwr));
    check("m_bus_size",     32'(bus_size),     32'(e_bsize));
    check("m_bus_wstrb",    32'(bus_wstrb),    32'(e_bwstrb));
    check("m_bus_addr",     bus_addr,          e_baddr);
    check("m_bus_wdata",    bus_wdata,         e_bwdata);
    check("m_inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
    check("m_inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
    check("m_inst_rdata",   inst_rdata,        e_irdata);
    check("m_data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
    check("m_data_data_ok", 32'(data_data_ok), 32'(e_ddok));
    check("m_data_rdata",   data_rdata,        e_drdata);
`ifdef ARB_PERF_CNT_EN
    check("m_perf_inst", perf_inst_cnt, pc_inst);
    check("m_perf_data", perf_data_cnt, pc_data);
    check("m_perf_wait", perf_wait_cnt, pc_wait);
`endif
    if (!rst_n) begin
      m_busy <= 0; m_inst <= 0; m_acc <= 0; m_drop <= 0; m_streak <= 0;
      pc_inst <= 0; pc_data <= 0; pc_wait <= 0;
    end else begin
      if (e_idok) pc_inst <= pc_inst + 32'd1;
      if (e_ddok) pc_data <= pc_data + 32'd1;
      if ((inst_req && !e_iaok) || (data_req && !e_daok)) pc_wait <= pc_wait + 32'd1;
      if (!m_busy) begin
        if (data_req && (m_streak < PRIO || !inst_req)) begin
          m_busy <= 1; m_inst <= 0; m_acc <= 0;
          m_streak <= inst_req ? ((m_streak + 1 > PRIO) ? PRIO : m_streak + 1) : 0;
        end else if (inst_req) begin
          m_busy <= 1; m_inst <= 1; m_acc <= 0; m_drop <= 0; m_streak <= 0;
        end
      end else if (!m_acc) begin
        if (bus_addr_ok) begin
          m_acc <= 1;
          if (m_inst) m_drop <= inst_cancel;
        end else if (m_inst && inst_cancel) begin
          m_busy <= 0;
        end
      end else if (bus_data_ok) begin
        m_busy <= 0; m_drop <= 0;
      end else if (m_inst && inst_cancel) begin
        m_drop <= 1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  bit bus_out;   // bridge holds an accepted, unanswered transaction
  bit i_hs, d_hs;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bridge: accepts only while bus_req is up, answers at least one cycle
  // later. In random mode it also injects responses where they must be
  // ignored, never data_ok together with addr_ok in an address phase.
  task automatic bridge_step(input bit rnd);
    bus_rdata = $urandom;
    if (!rst_n) begin
      bus_out = 0; bus_addr_ok = 0; bus_data_ok = 0;
    end else if (bus_out) begin
      bus_addr_ok = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      bus_data_ok = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (bus_data_ok) bus_out = 0;
    end else if (bus_req) begin
      bus_addr_ok = rnd ? ($urandom_range(0, 1) == 0) : 1'b1;
      bus_data_ok = !bus_addr_ok && rnd && ($urandom_range(0, 7) == 0);
      if (bus_addr_ok) bus_out = 1;
    end else begin
      bus_addr_ok = rnd && ($urandom_range(0, 7) == 0);
      bus_data_ok = rnd && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic new_data();
    data_req   = 1;
    data_wr    = 1'($urandom_range(0, 1));
    data_size  = 2'($urandom_range(0, 2));
    data_wstrb = 4'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  task automatic req_step();
    if ($urandom_range(0, 599) == 0) begin
      rst_n = 0; inst_req = 0; data_req = 0; inst_cancel = 0;
      i_hs = 0; d_hs = 0;
      return;
    end
    rst_n = 1;
    if (i_hs) begin
      inst_req  = 1'($urandom_range(0, 1));
      inst_addr = $urandom & 32'hffff_fffc;
    end else if (!inst_req && $urandom_range(0, 2) == 0) begin
      inst_req  = 1;
      inst_addr = $urandom & 32'hffff_fffc;
    end
    inst_cancel = ($urandom_range(0, 9) == 0);
    if (inst_cancel && inst_req) inst_addr = $urandom & 32'hffff_fffc;
    if (d_hs) begin
      if ($urandom_range(0, 1) == 0) new_data();
      else data_req = 0;
    end else if (!data_req && $urandom_range(0, 2) == 0) begin
      new_data();
    end
  endtask

  int grants[6];
  int ng;
  int exp_grant[6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    rst_n = 0; inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    bus_out = 0; i_hs = 0; d_hs = 0;

    repeat (2) cyc();
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
`ifdef ARB_PERF_CNT_EN
    check("reset_perf_wait", perf_wait_cnt, 32'd0);
`endif
    cyc(); rst_n = 1;
    cyc();

    // Lone fetch
    cyc(); inst_req = 1; inst_addr = 32'hbfc00000; #1;
    check("fetch_idle_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1; #1;
    check("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("fetch_bus_addr", bus_addr, 32'hbfc00000);
    cyc(); inst_req = 0; bus_addr_ok = 0; #1;
    check("fetch_wait_data_ok", 32'(inst_data_ok), 32'd0);
    cyc();
    cyc(); bus_data_ok = 1; bus_rdata = 32'h3c080001; #1;
    check("fetch_data_ok", 32'(inst_data_ok), 32'd1);
    check("fetch_rdata", inst_rdata, 32'h3c080001);
    cyc(); bus_data_ok = 0; bus_rdata = 0; #1;
    check("fetch_back_idle", 32'(bus_req), 32'd0);

    // Simultaneous requests: data first
    cyc(); inst_req = 1; inst_addr = 32'hbfc00004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hf;
    data_addr = 32'h80001000; data_wdata = 32'hdeadbeef;
    cyc(); bus_addr_ok = 1; #1;
    check("sim_bus_req", 32'(bus_req), 32'd1);
    check("sim_bus_wr", 32'(bus_wr), 32'd1);
    check("sim_bus_addr", bus_addr, 32'h80001000);
    check("sim_bus_wdata", bus_wdata, 32'hdeadbeef);
    check("sim_bus_wstrb", 32'(bus_wstrb), 32'hf);
    check("sim_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("sim_no_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc(); data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0; data_size = 0;
    bus_addr_ok = 0; #1;
    check("sim_ddata_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_data_ok = 1; #1;
    check("sim_data_data_ok", 32'(data_data_ok), 32'd1);
    cyc(); bus_data_ok = 0; #1;
    check("sim_idle_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1; #1;
    check("sim_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("sim_inst_bus_addr", bus_addr, 32'hbfc00004);
    cyc(); inst_req = 0; bus_addr_ok = 0;
    cyc(); bus_data_ok = 1; bus_rdata = 32'h11111111; #1;
    check("sim_inst_data_ok", 32'(inst_data_ok), 32'd1);
    cyc(); bus_data_ok = 0;

    // Cancel during I_DATA
    cyc(); inst_req = 1; inst_addr = 32'hbfc00008;
    cyc(); bus_addr_ok = 1;
    cyc(); inst_req = 0; bus_addr_ok = 0; inst_cancel = 1;
    cyc(); inst_cancel = 0;
    cyc(); bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
    check("idata_cancel_data_ok", 32'(inst_data_ok), 32'd0);
    check("idata_cancel_rdata", inst_rdata, 32'd0);
    cyc(); bus_data_ok = 0; inst_req = 1; inst_addr = 32'hbfc0000c;
    cyc(); bus_addr_ok = 1; #1;
    check("refetch_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("refetch_bus_addr", bus_addr, 32'hbfc0000c);
    cyc(); inst_req = 0; bus_addr_ok = 0;
    cyc(); bus_data_ok = 1; bus_rdata = 32'h24682468; #1;
    check("refetch_data_ok", 32'(inst_data_ok), 32'd1);
    check("refetch_rdata", inst_rdata, 32'h24682468);
    cyc(); bus_data_ok = 0;

    // Cancel during I_ADDR
    cyc(); inst_req = 1; inst_addr = 32'hbfc00010;
    cyc(); inst_cancel = 1; #1;
    check("iaddr_cancel_bus_req", 32'(bus_req), 32'd1);
    check("iaddr_cancel_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc(); inst_cancel = 0; inst_req = 0; #1;
    check("iaddr_cancel_bus_drop", 32'(bus_req), 32'd0);
    check("iaddr_cancel_no_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc(); #1;
    check("iaddr_cancel_idle", 32'(bus_req), 32'd0);

    // Starvation limit: data and inst held continuously
    inst_req = 1; inst_addr = 32'hbfc00020;
    data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = 32'h80002000; data_wdata = 0;
    ng = 0;
    for (int k = 0; k < 60 && ng < 6; k++) begin
      cyc(); bridge_step(0); #1;
      if (inst_addr_ok) begin grants[ng] = 1; ng++; end
      else if (data_addr_ok) begin grants[ng] = 0; ng++; end
    end
    for (int k = ng; k < 6; k++) grants[k] = -1;
    inst_req = 0; data_req = 0;
    repeat (4) begin cyc(); bridge_step(0); end
    for (int k = 0; k < 6; k++)
      check($sformatf("starve_grant_%0d_is_inst", k), 32'(grants[k]), 32'(exp_grant[k]));
    cyc(); bus_addr_ok = 0; bus_data_ok = 0;

    // Reset in D_DATA
    cyc(); data_req = 1; data_addr = 32'h00001000;
    cyc(); bus_addr_ok = 1;
    cyc(); data_req = 0; bus_addr_ok = 0; #1;
    check("rst_pre_ddata", 32'(bus_req), 32'd0);
    cyc(); rst_n = 0; bus_data_ok = 1; bus_rdata = 32'haaaa5555; inst_req = 1; #1;
    check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
`ifdef ARB_PERF_CNT_EN
    check("rst_perf_inst", perf_inst_cnt, 32'd0);
    check("rst_perf_data", perf_data_cnt, 32'd0);
    check("rst_perf_wait", perf_wait_cnt, 32'd0);
`endif
    cyc(); rst_n = 1; bus_data_ok = 0; inst_req = 0; bus_out = 0; #1;
    check("rst_release_idle", 32'(bus_req), 32'd0);
    cyc(); #1;
    check("rst_stays_idle", 32'(bus_req), 32'd0);

    // Randomized traffic
    i_hs = 0; d_hs = 0;
    for (int k = 0; k < 3000; k++) begin
      cyc();
      req_step();
      bridge_step(1);
      #1;
      i_hs = rst_n && inst_req && inst_addr_ok;
      d_hs = rst_n && data_req && data_addr_ok;
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage instruction fetch (the PC stage's inst_sram interface) and the MEM-stage data access.
- Grants with data priority and a starvation limit, and keeps only one transaction outstanding.
- Discards in-flight instruction responses when the controller flushes the fetch stage.
- Sits between the core (IF/MEM stages) and the SRAM-like-to-AXI bridge.

Parameters:
- DATA_PRIO_MAX, 4: consecutive data grants allowed while inst_req is pending before inst is forced.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_cancel  in  1  fetch flush from controller (if_flush)
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetched instruction
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data read valid / write done
- data_rdata  out  32  read data
- bus_req  out  1  to bridge
- bus_wr  out  1  to bridge
- bus_size  out  2  to bridge
- bus_wstrb  out  4  to bridge
- bus_addr  out  32  to bridge
- bus_wdata  out  32  to bridge
- bus_addr_ok  in  1  from bridge
- bus_data_ok  in  1  from bridge
- bus_rdata  in  32  from bridge

Behaviour:
- Reset is asynchronous and active-low: clk and rst_n; reset forces IDLE, the counter to 0, the drop flag to 0, and all outputs to 0.
- States:
  - IDLE: grant decision registered.
    - data_req and (cnt < DATA_PRIO_MAX or !inst_req) -> D_ADDR.
    - Otherwise inst_req -> I_ADDR.
    - Otherwise stay in IDLE.
  - D_ADDR: bus_req = 1; bus fields mirror the data_* inputs.
    - data_addr_ok = bus_addr_ok.
    - On bus_addr_ok -> D_DATA.
  - D_DATA: bus_req = 0.
    - On bus_data_ok: data_data_ok = 1, data_rdata = bus_rdata, then -> IDLE.
  - I_ADDR: bus_req = 1, bus_wr = 0, bus_size = 2, bus_wstrb = 0, bus_addr = inst_addr.
    - inst_addr_ok = bus_addr_ok.
    - On bus_addr_ok -> I_DATA.
    - If inst_cancel and !bus_addr_ok: abort -> IDLE; no bus transaction is issued.
  - I_DATA: waits for bus_data_ok.
    - inst_data_ok = bus_data_ok & !drop, inst_rdata = bus_rdata, then -> IDLE.
- Drop flag:
  - Set by inst_cancel in I_DATA, or in I_ADDR in the same cycle as bus_addr_ok.
  - Cleared on the bus_data_ok that ends the transaction.
- Combinational paths: addr_ok and data_ok are combinational from the bus; all grant decisions are registered.
- Minimum latency: req to addr_ok is 1 cycle; addr_ok to data_ok is at least 1 cycle.
- Starvation counter:
  - Increments on each data grant made while inst_req is high; saturates at DATA_PRIO_MAX.
  - Clears on any inst grant, or on a data grant with inst_req low.
- A bus_data_ok in the same cycle as bus_addr_ok in an _ADDR state is illegal; the bridge guarantees it never occurs.
- Responses in IDLE or in _ADDR states are ignored.
- Unselected requester outputs are 0; bus_wdata and bus_wstrb are 0 outside D_ADDR.
- Reset mid-transaction returns to IDLE; the bridge shares rst_n, so no stale response arrives.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs perf_inst_cnt[31:0], perf_data_cnt[31:0] and perf_wait_cnt[31:0].
  - perf_inst_cnt and perf_data_cnt count completed non-dropped inst / data transactions.
  - perf_wait_cnt counts cycles where a req is high but its addr_ok is low.
  - All three wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- defines.v: state width/encodings (`ArbStateW, `ArbIdle, `ArbDAddr, `ArbDData, `ArbIAddr, `ArbIData) and size codes (`SizeB, `SizeH, `SizeW).
- State, counter and drop registers use the existing DFFRE.
- One natural sub-module: arb_perf_cnt, instantiated only under ARB_PERF_CNT_EN.

Test Plan:
- Lone fetch:
  - Stimulus: inst_req, addr 0xbfc00000; bus_addr_ok on first I_ADDR cycle; bus_data_ok 2 cycles later with 0x3c080001.
  - Required: inst_addr_ok 1 cycle after req; inst_data_ok with 0x3c080001; state back to IDLE.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (write, size 2, wstrb 0xF, 0x80001000, 0xdeadbeef) in the same cycle.
  - Required: data granted first; bus fields match the data inputs; inst granted after data_data_ok.
- Starvation limit:
  - Stimulus: DATA_PRIO_MAX = 4; data_req held continuously with inst_req pending.
  - Required: exactly 4 data grants, then 1 inst grant, then data again.
- Cancel during I_DATA:
  - Stimulus: inst_cancel in I_DATA; bus_data_ok later returns 0x12345678.
  - Required: inst_data_ok stays 0; the next fetch is granted normally.
- Cancel during I_ADDR:
  - Stimulus: inst_cancel while bus_addr_ok is 0.
  - Required: bus_req drops next cycle; no inst_addr_ok.
- Reset mid-transaction:
  - Stimulus: rst_n low in D_DATA.
  - Required: all outputs 0 immediately; IDLE after release. With ARB_PERF_CNT_EN, counters read 0.
